// File: rtl/accel_sample_sched.sv
// Periodic accelerometer read scheduler with a per-axis change-threshold filter.
// Define ACCEL_SCHED_TIMEOUT_EN to bound how long rd_req waits for rd_ack.
module accel_sample_sched #(
    parameter int SAMPLE_DIV = 100000,
    parameter int TOL        = 75,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        rd_req,
    input  logic        rd_ack,
    input  logic [11:0] rd_x,
    input  logic [11:0] rd_y,
    output logic        smp_valid,
    output logic [11:0] smp_x,
    output logic [11:0] smp_y,
    output logic        busy,
    output logic        missed_tick,
    output logic        timeout_err
);
    localparam int DATA_W = 12;
    localparam int CNT_W  = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CNT_W-1:0] TICK_LAST = CNT_W'(SAMPLE_DIV - 1);
    localparam logic [DATA_W:0]  TOL_W     = (DATA_W + 1)'(TOL);

    typedef enum logic [1:0] {
        S_WAIT,
        S_REQ,
        S_CHECK
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  tick_cnt;
    logic              tick;
    logic              first_smp;
    logic [DATA_W-1:0] cap_x_p1;
    logic [DATA_W-1:0] cap_y_p1;
    logic [DATA_W:0]   diff_x;
    logic [DATA_W:0]   diff_y;
    logic              accept;

    // Sign-magnitude to two's complement; -0 collapses to 0.
    function automatic logic signed [DATA_W:0] sm_to_signed(input logic [DATA_W-1:0] v);
        logic signed [DATA_W:0] mag;
        mag = $signed({2'b00, v[DATA_W-2:0]});
        return v[DATA_W-1] ? -mag : mag;
    endfunction

    function automatic logic [DATA_W:0] abs_diff(input logic signed [DATA_W:0] a,
                                                  input logic signed [DATA_W:0] b);
        logic signed [DATA_W+1:0] d;
        d = $signed({a[DATA_W], a}) - $signed({b[DATA_W], b});
        return (DATA_W + 1)'(d[DATA_W+1] ? -d : d);
    endfunction

    assign tick   = en && (tick_cnt == TICK_LAST);
    assign busy   = (state != S_WAIT);
    assign diff_x = abs_diff(sm_to_signed(cap_x_p1), sm_to_signed(smp_x));
    assign diff_y = abs_diff(sm_to_signed(cap_y_p1), sm_to_signed(smp_y));
    assign accept = first_smp || (diff_x > TOL_W) || (diff_y > TOL_W);

`ifdef ACCEL_SCHED_TIMEOUT_EN
    localparam int TO_W = 10;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
    logic [TO_W-1:0] to_cnt;
    logic            to_err;
    assign timeout_err = to_err;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_WAIT;
            tick_cnt    <= '0;
            rd_req      <= 1'b0;
            smp_valid   <= 1'b0;
            smp_x       <= '0;
            smp_y       <= '0;
            missed_tick <= 1'b0;
            first_smp   <= 1'b1;
`ifdef ACCEL_SCHED_TIMEOUT_EN
            to_cnt      <= '0;
            to_err      <= 1'b0;
`endif
        end else begin
            smp_valid <= 1'b0;

            if (!en || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + CNT_W'(1);
            end

            case (state)
                S_WAIT: begin
                    if (tick) begin
                        state  <= S_REQ;
                        rd_req <= 1'b1;
`ifdef ACCEL_SCHED_TIMEOUT_EN
                        to_cnt <= '0;
`endif
                    end
                end

                // Capture stage: data lands in cap_*_p1 on the ack edge
                S_REQ: begin
                    if (tick) begin
                        missed_tick <= 1'b1;
                    end
                    if (rd_ack) begin
                        cap_x_p1 <= rd_x;
                        cap_y_p1 <= rd_y;
                        rd_req   <= 1'b0;
                        state    <= S_CHECK;
                    end
`ifdef ACCEL_SCHED_TIMEOUT_EN
                    else if (to_cnt == TO_LAST) begin
                        rd_req <= 1'b0;
                        to_err <= 1'b1;
                        state  <= S_WAIT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
`endif
                end

                // Filter stage: compare against last accepted sample
                S_CHECK: begin
                    if (tick) begin
                        missed_tick <= 1'b1;
                    end
                    if (accept) begin
                        smp_x     <= cap_x_p1;
                        smp_y     <= cap_y_p1;
                        smp_valid <= 1'b1;
                        first_smp <= 1'b0;
                    end
                    state <= S_WAIT;
                end

                default: begin
                    state  <= S_WAIT;
                    rd_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_sample_sched.sv
// Self-checking bench for accel_sample_sched: vector table, randomized reads against
// a transaction-level model, and hand-written missed-tick / enable / timeout / reset cases.
`timescale 1ns/1ps
module tb_accel_sample_sched;
    localparam int SAMPLE_DIV = 8;
    localparam int TOL        = 75;
    localparam int TIMEOUT    = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        rd_req;
    logic        rd_ack;
    logic [11:0] rd_x;
    logic [11:0] rd_y;
    logic        smp_valid;
    logic [11:0] smp_x;
    logic [11:0] smp_y;
    logic        busy;
    logic        missed_tick;
    logic        timeout_err;

    accel_sample_sched #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .TOL       (TOL),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .rd_req     (rd_req),
        .rd_ack     (rd_ack),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .smp_valid  (smp_valid),
        .smp_x      (smp_x),
        .smp_y      (smp_y),
        .busy       (busy),
        .missed_tick(missed_tick),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: last accepted sample, first-sample flag, sticky flags
    logic [11:0] m_sx, m_sy;
    bit          m_first, m_missed, m_toerr;
    int          last_rise;

    typedef struct {
        logic [11:0] x;
        logic [11:0] y;
        bit          pulse;
        logic [11:0] ex;
        logic [11:0] ey;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int sm2int(input logic [11:0] v);
        int m;
        m = int'({21'd0, v[10:0]});
        return v[11] ? -m : m;
    endfunction

    function automatic logic [11:0] int2sm(input int v);
        int a;
        if (v > 2047)  v = 2047;
        if (v < -2047) v = -2047;
        a = (v < 0) ? -v : v;
        return {(v < 0), a[10:0]};
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // Wait (bounded) for rd_req to rise; check idle outputs and the tick spacing.
    task automatic wait_rise(input int exp_gap, input string name, input bit spur);
        int waited = 0;
        bit idle_ok = 1'b1;
        while (rd_req !== 1'b1 && waited < 200) begin
            if (smp_valid !== 1'b0 || busy !== 1'b0) idle_ok = 1'b0;
            rd_ack = spur && ($urandom_range(3) == 0);
            rd_x   = 12'($urandom);
            rd_y   = 12'($urandom);
            @(negedge clk);
            waited++;
        end
        rd_ack = 1'b0;
        check({name, " idle"}, 32'(idle_ok), 32'd1);
        check({name, " rd_req_rise"}, 32'(rd_req), 32'd1);
        if (exp_gap > 0) check({name, " gap"}, cyc - last_rise, exp_gap);
        last_rise = cyc;
    endtask

    task automatic do_read(input logic [11:0] x, input logic [11:0] y, input int delay,
                           input bit exp_pulse, input logic [11:0] ex, input logic [11:0] ey,
                           input int exp_gap, input string name, input bit spur,
                           input bit drop_en);
        wait_rise(exp_gap, name, spur);
        if (rd_req !== 1'b1) return;
        if (drop_en) en = 1'b0;
        repeat (delay) @(negedge clk);
        check({name, " rd_req_held"}, 32'(rd_req), 32'd1);
        rd_ack = 1'b1;
        rd_x   = x;
        rd_y   = y;
        @(negedge clk);
        rd_ack = 1'b0;
        rd_x   = 12'($urandom);
        rd_y   = 12'($urandom);
        check({name, " rd_req_drop"}, 32'(rd_req), 32'd0);
        check({name, " valid_early"}, 32'(smp_valid), 32'd0);
        check({name, " busy_check"}, 32'(busy), 32'd1);
        @(negedge clk);
        check({name, " smp_valid"}, 32'(smp_valid), 32'(exp_pulse));
        check({name, " smp_x"}, 32'(smp_x), 32'(ex));
        check({name, " smp_y"}, 32'(smp_y), 32'(ey));
        check({name, " busy_wait"}, 32'(busy), 32'd0);
        @(negedge clk);
        check({name, " valid_1cyc"}, 32'(smp_valid), 32'd0);
        check({name, " smp_x_hold"}, 32'(smp_x), 32'(ex));
        check({name, " missed_tick"}, 32'(missed_tick), 32'(m_missed));
        check({name, " timeout_err"}, 32'(timeout_err), 32'(m_toerr));
    endtask

    task automatic model_read(input logic [11:0] x, input logic [11:0] y, input int delay,
                              input int exp_gap, input string name, input bit spur,
                              input bit drop_en);
        bit acc;
        acc = m_first || (iabs(sm2int(x) - sm2int(m_sx)) > TOL)
                      || (iabs(sm2int(y) - sm2int(m_sy)) > TOL);
        if (acc) begin
            m_sx    = x;
            m_sy    = y;
            m_first = 1'b0;
        end
        do_read(x, y, delay, acc, m_sx, m_sy, exp_gap, name, spur, drop_en);
    endtask

    function automatic logic [11:0] rand_val(input logic [11:0] cur);
        int off;
        if ($urandom_range(1) == 0) return 12'($urandom);
        off = int'($urandom_range(160)) - 80;
        return int2sm(sm2int(cur) + off);
    endfunction

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got running, expected done");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{12'h064, 12'h000, 1'b1, 12'h064, 12'h000};
        tbl[1]  = '{12'h08C, 12'h000, 1'b0, 12'h064, 12'h000};
        tbl[2]  = '{12'h8B4, 12'h000, 1'b1, 12'h8B4, 12'h000};
        tbl[3]  = '{12'h064, 12'h000, 1'b1, 12'h064, 12'h000};
        tbl[4]  = '{12'h0AF, 12'h000, 1'b0, 12'h064, 12'h000};
        tbl[5]  = '{12'h0B0, 12'h000, 1'b1, 12'h0B0, 12'h000};
        tbl[6]  = '{12'h0B0, 12'h84C, 1'b1, 12'h0B0, 12'h84C};
        tbl[7]  = '{12'h0B0, 12'h84B, 1'b0, 12'h0B0, 12'h84C};
        tbl[8]  = '{12'h800, 12'h84C, 1'b1, 12'h800, 12'h84C};
        tbl[9]  = '{12'h000, 12'h84C, 1'b0, 12'h800, 12'h84C};
        tbl[10] = '{12'h7FF, 12'hFFF, 1'b1, 12'h7FF, 12'hFFF};
        tbl[11] = '{12'hFFF, 12'h7FF, 1'b1, 12'hFFF, 12'h7FF};
        tbl[12] = '{12'hFB4, 12'h7FF, 1'b0, 12'hFFF, 12'h7FF};
        tbl[13] = '{12'hFB3, 12'h7FF, 1'b1, 12'hFB3, 12'h7FF};

        rst = 1'b1; en = 1'b0; rd_ack = 1'b0; rd_x = '0; rd_y = '0;
        m_sx = '0; m_sy = '0; m_first = 1'b1; m_missed = 1'b0; m_toerr = 1'b0;
        repeat (3) @(negedge clk);
        check("rst rd_req", 32'(rd_req), 32'd0);
        check("rst smp_valid", 32'(smp_valid), 32'd0);
        check("rst smp_x", 32'(smp_x), 32'd0);
        check("rst smp_y", 32'(smp_y), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst missed_tick", 32'(missed_tick), 32'd0);
        check("rst timeout_err", 32'(timeout_err), 32'd0);

        rst = 1'b0; en = 1'b1; last_rise = cyc;
        foreach (tbl[i]) begin
            do_read(tbl[i].x, tbl[i].y, 3, tbl[i].pulse, tbl[i].ex, tbl[i].ey, SAMPLE_DIV,
                    $sformatf("vec%0d", i), 1'b0, 1'b0);
            if (tbl[i].pulse) begin
                m_sx = tbl[i].ex; m_sy = tbl[i].ey; m_first = 1'b0;
            end
        end

        for (int i = 0; i < 30; i++) begin
            model_read(rand_val(m_sx), rand_val(m_sy), int'($urandom_range(4)), SAMPLE_DIV,
                       $sformatf("rnd%0d", i), 1'b1, 1'b0);
        end

        // Slow reader: the tick during REQ is dropped, next request one tick later
        m_missed = 1'b1;
        model_read(int2sm(sm2int(m_sx) + 500), m_sy, 10, SAMPLE_DIV, "miss", 1'b0, 1'b0);
        model_read(rand_val(m_sx), rand_val(m_sy), 3, 2 * SAMPLE_DIV, "after_miss", 1'b0, 1'b0);

        // en dropped mid-read: read completes, then no requests until re-enabled
        model_read(int2sm(sm2int(m_sx) - 300), m_sy, 2, SAMPLE_DIV, "en_drop", 1'b0, 1'b1);
        begin
            bit quiet = 1'b1;
            repeat (30) begin
                @(negedge clk);
                if (rd_req !== 1'b0) quiet = 1'b0;
            end
            check("en_low quiet", 32'(quiet), 32'd1);
        end
        en = 1'b1; last_rise = cyc;
        model_read(rand_val(m_sx), rand_val(m_sy), 3, SAMPLE_DIV, "re_en", 1'b1, 1'b0);

`ifdef ACCEL_SCHED_TIMEOUT_EN
        begin
            int hi = 0;
            wait_rise(SAMPLE_DIV, "to", 1'b0);
            while (rd_req === 1'b1 && hi < 60) begin
                hi++;
                @(negedge clk);
            end
            check("to rd_req_len", hi, TIMEOUT);
            check("to timeout_err", 32'(timeout_err), 32'd1);
            check("to busy", 32'(busy), 32'd0);
            m_toerr = 1'b1;
            model_read(rand_val(m_sx), rand_val(m_sy), 3, 3 * SAMPLE_DIV, "to_retry", 1'b1, 1'b0);
            wait_rise(SAMPLE_DIV, "pre_rst", 1'b0);
        end
`else
        begin
            bit held = 1'b1;
            wait_rise(SAMPLE_DIV, "no_to", 1'b0);
            repeat (40) begin
                @(negedge clk);
                if (rd_req !== 1'b1) held = 1'b0;
            end
            check("no_to rd_req_held", 32'(held), 32'd1);
            check("no_to timeout_err", 32'(timeout_err), 32'd0);
            check("no_to busy", 32'(busy), 32'd1);
        end
`endif

        // Reset while rd_req is high
        rst = 1'b1;
        @(negedge clk);
        check("midrst rd_req", 32'(rd_req), 32'd0);
        check("midrst smp_valid", 32'(smp_valid), 32'd0);
        check("midrst smp_x", 32'(smp_x), 32'd0);
        check("midrst smp_y", 32'(smp_y), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst missed_tick", 32'(missed_tick), 32'd0);
        check("midrst timeout_err", 32'(timeout_err), 32'd0);
        rst = 1'b0; last_rise = cyc;
        m_sx = '0; m_sy = '0; m_first = 1'b1; m_missed = 1'b0; m_toerr = 1'b0;
        do_read(12'h000, 12'h000, 3, 1'b1, 12'h000, 12'h000, SAMPLE_DIV, "post_rst", 1'b0, 1'b0);
        m_first = 1'b0;
        model_read(12'h010, 12'h000, 3, SAMPLE_DIV, "post_rst2", 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
